uart_cmd_switch_bank: RTL and testbench

//  Parametrised UART command decoder driving NCH latched switch channels from 2-byte ASCII commands
//  "<ID><OP>". Sits between uart_rx (rx_data/rx_valid) and actuator logic (motors, servos).

---
 rtl/uart_cmd_switch_bank.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_switch_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_switch_bank.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_switch_bank
// Description : Decodes 2-byte ASCII commands "<ID><OP>" from a UART receiver
//               into NCH latched switch channels. Produces level state,
//               rise/fall pulses, error pulses and an ASCII ack stream
//               ('K' / 'E') through a 2-entry FIFO for a UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_switch_bank #(
    parameter int         NCH     = 5,
    parameter logic [7:0] BASE_ID = 8'h47,
    parameter int         GAP_CYC = 50000,
    parameter bit         ACK_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic [NCH-1:0] ch_state,
    output logic [NCH-1:0] rise_pulse,
    output logic [NCH-1:0] fall_pulse,
    output logic           err_pulse,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           ack_drop
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int GW = $clog2(GAP_CYC);

    localparam logic [8:0]    c_nch      = 9'(NCH);
    localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYC - 1);
    localparam logic [7:0]    c_star     = 8'h2A;
    localparam logic [7:0]    c_cr       = 8'h0D;
    localparam logic [7:0]    c_lf       = 8'h0A;
    localparam logic [7:0]    c_sp       = 8'h20;
    localparam logic [7:0]    c_op_set   = 8'h31;
    localparam logic [7:0]    c_op_clr   = 8'h30;
    localparam logic [7:0]    c_op_tog   = 8'h54;
    localparam logic [7:0]    c_ack_ok   = 8'h4B;
    localparam logic [7:0]    c_ack_err  = 8'h45;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_WAIT_OP = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_all;
    logic [IW-1:0]  r_idx;
    logic [GW-1:0]  r_gap;
    logic [GW-1:0]  w_gap_nxt;
    logic [NCH-1:0] r_ch;
    logic [NCH-1:0] r_ch_d;
    logic [NCH-1:0] w_ch_nxt;
    logic [NCH-1:0] w_mask;
    logic           r_err;
    logic           w_err;
    logic           w_load_id;
    logic           w_load_all;
    logic           w_ack_push;
    logic [7:0]     w_ack_byte;
    logic [7:0]     w_off;
    logic           w_id_hit;

    // Channel offset of the received byte; the 8-bit wrap makes bytes below BASE_ID land out of range.
    assign w_off    = rx_data - BASE_ID;
    assign w_id_hit = ({1'b0, w_off} < c_nch);

    // Target mask of the pending command: one channel, or every channel for '*'.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            w_mask[i] = r_all | (r_idx == IW'(i));
        end
    end

    // Next-state, channel update, error and ack generation.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = '0;
        w_load_id   = 1'b0;
        w_load_all  = 1'b0;
        w_ch_nxt    = r_ch;
        w_err       = 1'b0;
        w_ack_push  = 1'b0;
        w_ack_byte  = c_ack_ok;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (w_id_hit) begin
                        w_load_id   = 1'b1;
                        w_state_nxt = S_WAIT_OP;
                    end else if (rx_data == c_star) begin
                        w_load_id   = 1'b1;
                        w_load_all  = 1'b1;
                        w_state_nxt = S_WAIT_OP;
                    end else if ((rx_data == c_cr) || (rx_data == c_lf) || (rx_data == c_sp)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err      = 1'b1;
                        w_ack_push = 1'b1;
                        w_ack_byte = c_ack_err;
                    end
                end
            end
            S_WAIT_OP: begin
                if (rx_valid) begin
                    // A byte arriving in the expiry cycle still counts as the OP.
                    w_state_nxt = S_IDLE;
                    w_ack_push  = 1'b1;
                    if (rx_data == c_op_set) begin
                        w_ch_nxt = r_ch | w_mask;
                    end else if (rx_data == c_op_clr) begin
                        w_ch_nxt = r_ch & ~w_mask;
                    end else if (rx_data == c_op_tog) begin
                        w_ch_nxt = r_ch ^ w_mask;
                    end else begin
                        w_err      = 1'b1;
                        w_ack_byte = c_ack_err;
                    end
                end else if (r_gap == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                    w_ack_push  = 1'b1;
                    w_ack_byte  = c_ack_err;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command target capture, gap counter, channel levels and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all  <= 1'b0;
            r_idx  <= '0;
            r_gap  <= '0;
            r_ch   <= '0;
            r_ch_d <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_load_id) begin
                r_all <= w_load_all;
                r_idx <= w_off[IW-1:0];
            end
            r_gap  <= w_gap_nxt;
            r_ch   <= w_ch_nxt;
            r_ch_d <= r_ch;
            r_err  <= w_err;
        end
    end

    assign ch_state   = r_ch;
    assign rise_pulse = r_ch & ~r_ch_d;
    assign fall_pulse = ~r_ch & r_ch_d;
    assign err_pulse  = r_err;

    generate
        if (ACK_EN) begin : g_ack
            logic [7:0] r_mem [2];
            logic       r_rd;
            logic [1:0] r_cnt;
            logic       r_drop;
            logic       w_pop;
            logic       w_full;
            logic       w_wr_en;
            logic       w_wr_ptr;

            assign w_pop    = (r_cnt != 2'd0) && tx_ready;
            assign w_full   = (r_cnt == 2'd2);
            // A full FIFO still accepts a push when the head leaves in the same cycle.
            assign w_wr_en  = w_ack_push && (!w_full || w_pop);
            assign w_wr_ptr = r_rd ^ r_cnt[0];

            // Two-entry ack FIFO storage, pointers and drop pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[0] <= 8'h00;
                    r_mem[1] <= 8'h00;
                    r_rd     <= 1'b0;
                    r_cnt    <= 2'd0;
                    r_drop   <= 1'b0;
                end else begin
                    if (w_wr_en) begin
                        r_mem[w_wr_ptr] <= w_ack_byte;
                    end
                    if (w_pop) begin
                        r_rd <= ~r_rd;
                    end
                    r_cnt  <= r_cnt + {1'b0, w_wr_en} - {1'b0, w_pop};
                    r_drop <= w_ack_push && !w_wr_en;
                end
            end

            assign tx_valid = (r_cnt != 2'd0);
            assign tx_data  = tx_valid ? r_mem[r_rd] : 8'h00;
            assign ack_drop = r_drop;
        end else begin : g_no_ack
            logic w_unused_ack;
            assign w_unused_ack = &{1'b0, tx_ready, w_ack_push, w_ack_byte};
            assign tx_valid     = 1'b0;
            assign tx_data      = 8'h00;
            assign ack_drop     = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_switch_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_switch_bank
// Description : Self-checking bench for uart_cmd_switch_bank (NCH=5, 'G' base,
//               short gap timeout). Table of 2-byte commands plus directed
//               sequences for timeout, ack FIFO back-pressure and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_switch_bank;

    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] ch_state;
    logic [4:0] rise_pulse;
    logic [4:0] fall_pulse;
    logic       err_pulse;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ack_drop;

    int checks = 0;
    int errors = 0;

    uart_cmd_switch_bank #(
        .NCH     (5),
        .BASE_ID (8'h47),
        .GAP_CYC (GAP),
        .ACK_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .ch_state   (ch_state),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .err_pulse  (err_pulse),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ack_drop   (ack_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [7:0] op;
        logic [4:0] ch;
        logic [4:0] rise;
        logic [4:0] fall;
        logic       err;
        logic [7:0] ack;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Byte is captured at the posedge between the two negedges; returns in the following cycle.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h47, 8'h31, 5'b00001, 5'b00001, 5'b00000, 1'b0, 8'h4B}; // G1
        vecs[1]  = '{8'h49, 8'h31, 5'b00101, 5'b00100, 5'b00000, 1'b0, 8'h4B}; // I1
        vecs[2]  = '{8'h2A, 8'h54, 5'b11010, 5'b11010, 5'b00101, 1'b0, 8'h4B}; // *T
        vecs[3]  = '{8'h4A, 8'h31, 5'b11010, 5'b00000, 5'b00000, 1'b0, 8'h4B}; // J1 already set
        vecs[4]  = '{8'h48, 8'h30, 5'b11000, 5'b00000, 5'b00010, 1'b0, 8'h4B}; // H0
        vecs[5]  = '{8'h4B, 8'h54, 5'b01000, 5'b00000, 5'b10000, 1'b0, 8'h4B}; // KT
        vecs[6]  = '{8'h49, 8'h58, 5'b01000, 5'b00000, 5'b00000, 1'b1, 8'h45}; // IX bad op
        vecs[7]  = '{8'h2A, 8'h31, 5'b11111, 5'b10111, 5'b00000, 1'b0, 8'h4B}; // *1
        vecs[8]  = '{8'h2A, 8'h30, 5'b00000, 5'b00000, 5'b11111, 1'b0, 8'h4B}; // *0
        vecs[9]  = '{8'h47, 8'h30, 5'b00000, 5'b00000, 5'b00000, 1'b0, 8'h4B}; // G0 already clear
        vecs[10] = '{8'h4B, 8'h31, 5'b10000, 5'b10000, 5'b00000, 1'b0, 8'h4B}; // K1

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ch",       32'(ch_state),   32'h0);
        check("rst_rise",     32'(rise_pulse), 32'h0);
        check("rst_err",      32'(err_pulse),  32'h0);
        check("rst_tx_valid", 32'(tx_valid),   32'h0);
        check("rst_tx_data",  32'(tx_data),    32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of complete commands, FIFO drained between entries.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].id);
            check($sformatf("v%0d_id_err", i), 32'(err_pulse), 32'h0);
            send(vecs[i].op);
            check($sformatf("v%0d_ch", i),       32'(ch_state),   32'(vecs[i].ch));
            check($sformatf("v%0d_rise", i),     32'(rise_pulse), 32'(vecs[i].rise));
            check($sformatf("v%0d_fall", i),     32'(fall_pulse), 32'(vecs[i].fall));
            check($sformatf("v%0d_err", i),      32'(err_pulse),  32'(vecs[i].err));
            check($sformatf("v%0d_tx_valid", i), 32'(tx_valid),   32'h1);
            check($sformatf("v%0d_tx_data", i),  32'(tx_data),    32'(vecs[i].ack));
            @(negedge clk);
            check($sformatf("v%0d_pulse_clr", i), 32'({rise_pulse, fall_pulse, err_pulse}), 32'h0);
            check($sformatf("v%0d_tx_empty", i),  32'(tx_valid), 32'h0);
        end

        // Inter-byte timeout after 'H': error only once the expiry cycle passes without a byte.
        send(8'h48);
        repeat (GAP - 1) @(negedge clk);
        check("to_err_early", 32'(err_pulse), 32'h0);
        @(negedge clk);
        check("to_err",      32'(err_pulse), 32'h1);
        check("to_tx_valid", 32'(tx_valid),  32'h1);
        check("to_tx_data",  32'(tx_data),   32'h45);
        @(negedge clk);
        check("to_err_once", 32'(err_pulse), 32'h0);
        send(8'h48);
        send(8'h31);
        check("to_h1_ch",   32'(ch_state),   32'b10010);
        check("to_h1_rise", 32'(rise_pulse), 32'b00010);
        send(8'h48);
        send(8'h30);
        check("h0_ch", 32'(ch_state), 32'b10000);

        // OP byte landing exactly in the expiry cycle is accepted.
        send(8'h48);
        repeat (GAP - 2) @(negedge clk);
        send(8'h31);
        check("exp_ch",      32'(ch_state),   32'b10010);
        check("exp_rise",    32'(rise_pulse), 32'b00010);
        check("exp_err",     32'(err_pulse),  32'h0);
        check("exp_tx_data", 32'(tx_data),    32'h4B);
        @(negedge clk);
        check("exp_err_late", 32'(err_pulse), 32'h0);

        // Ack FIFO back-pressure: two acks held, third dropped, actions still applied.
        @(negedge clk);
        tx_ready = 1'b0;
        send(8'h47); send(8'h31);
        send(8'h49); send(8'h31);
        check("bp_drop2", 32'(ack_drop), 32'h0);
        send(8'h4A); send(8'h31);
        check("bp_ch",       32'(ch_state), 32'b11111);
        check("bp_drop3",    32'(ack_drop), 32'h1);
        check("bp_tx_valid", 32'(tx_valid), 32'h1);
        @(negedge clk);
        check("bp_drop_once", 32'(ack_drop), 32'h0);
        check("bp_tx_hold",   32'(tx_data),  32'h4B);
        send(8'h47);
        // Full FIFO with push and pop in the same cycle: no drop.
        @(negedge clk);
        rx_data  = 8'h58;
        rx_valid = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        check("pp_err",      32'(err_pulse), 32'h1);
        check("pp_drop",     32'(ack_drop),  32'h0);
        check("pp_head_k",   32'(tx_data),   32'h4B);
        check("pp_ch",       32'(ch_state),  32'b11111);
        @(negedge clk);
        check("pp_valid_e",  32'(tx_valid),  32'h1);
        check("pp_head_e",   32'(tx_data),   32'h45);
        @(negedge clk);
        check("pp_empty",    32'(tx_valid),  32'h0);

        // Bad ID, then whitespace bytes ignored silently.
        send(8'h5A);
        check("z_err",  32'(err_pulse), 32'h1);
        check("z_ack",  32'(tx_data),   32'h45);
        send(8'h0D);
        check("cr_err", 32'({err_pulse, tx_valid}), 32'h0);
        send(8'h0A);
        check("lf_err", 32'({err_pulse, tx_valid}), 32'h0);
        send(8'h20);
        check("sp_err", 32'({err_pulse, tx_valid}), 32'h0);
        send(8'h4C);
        check("id_range_err", 32'(err_pulse), 32'h1);
        send(8'h47);
        send(8'h30);
        check("g0_ch",   32'(ch_state),   32'b11110);
        check("g0_fall", 32'(fall_pulse), 32'b00001);
        check("g0_err",  32'(err_pulse),  32'h0);

        // Reset between ID and OP discards the partial command.
        send(8'h49);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ch",   32'(ch_state),   32'h0);
        check("mid_rst_fall", 32'(fall_pulse), 32'h0);
        check("mid_rst_tx",   32'(tx_valid),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h31);
        check("post_rst_err", 32'(err_pulse),  32'h1);
        check("post_rst_ch",  32'(ch_state),   32'h0);
        check("post_rst_ack", 32'(tx_data),    32'h45);
        check("post_rst_rise", 32'(rise_pulse), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
